// File: rtl/demux_n_stream.sv
// rtl/demux_n_stream.sv - registered 1-to-NUM_CH stream demultiplexer with valid/ready handshake
//
// Routes one input word per cycle into one of NUM_CH single-entry output slots.
// The target is sel_i (SEL_MODE=0) or an internal round-robin pointer (SEL_MODE=1).
// Empty slots drive zero on their data slice.
//
// Optional feature macro: DEMUX_BROADCAST_EN (adds bcast_i; a broadcast word loads every slot).
//
// Ports:
//   clk_i    clock, rising edge
//   rst_i    asynchronous active-high reset
//   data_i   input word
//   valid_i  input word valid
//   ready_o  input accepted when valid_i && ready_o
//   sel_i    target channel (SEL_MODE=0 only)
//   data_o   slot k at bits [k*DATA_WIDTH +: DATA_WIDTH]
//   valid_o  slot k holds a word
//   ready_i  consumer k takes slot k when valid_o[k] && ready_i[k]
//   ptr_o    round-robin pointer (0 when SEL_MODE=0)
//   drop_o   1-cycle pulse: a word was accepted for a non-existent channel
//   bcast_i  broadcast request (DEMUX_BROADCAST_EN only)
module demux_n_stream #(
  parameter int DATA_WIDTH = 8,
  parameter int NUM_CH     = 4,
  parameter int SEL_MODE   = 0,
  localparam int SEL_WIDTH = $clog2(NUM_CH)
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic [DATA_WIDTH-1:0]        data_i,
  input  logic                         valid_i,
  output logic                         ready_o,
  input  logic [SEL_WIDTH-1:0]         sel_i,
  output logic [NUM_CH*DATA_WIDTH-1:0] data_o,
  output logic [NUM_CH-1:0]            valid_o,
  input  logic [NUM_CH-1:0]            ready_i,
`ifdef DEMUX_BROADCAST_EN
  input  logic                         bcast_i,
`endif
  output logic [SEL_WIDTH-1:0]         ptr_o,
  output logic                         drop_o
);

  logic [SEL_WIDTH-1:0] ptr_q;
  logic [SEL_WIDTH-1:0] tgt;
  logic [NUM_CH-1:0]    free;
  logic [NUM_CH-1:0]    load;
  logic                 bcast;
  logic                 tgt_ok;
  logic                 tgt_free;
  logic                 accept;
  logic                 drop_d;

`ifdef DEMUX_BROADCAST_EN
  assign bcast = bcast_i;
`else
  assign bcast = 1'b0;
`endif

  // A slot can take a new word if it is empty or is being drained this cycle.
  assign free = ~valid_o | ready_i;
  assign tgt  = (SEL_MODE != 0) ? ptr_q : sel_i;

  always_comb begin
    tgt_ok   = 1'b0;
    tgt_free = 1'b1;
    load     = '0;
    // Decode the target by comparison so out-of-range codes (non power-of-2
    // NUM_CH) never index past the slot vector; they fall through as "free".
    for (int k = 0; k < NUM_CH; k++) begin
      if (tgt == SEL_WIDTH'(k)) begin
        tgt_ok   = 1'b1;
        tgt_free = free[k];
      end
    end
    // Broadcast ready is gated by bcast_i only, not valid_i, so ready_o never
    // depends combinationally on valid_i; it is identical whenever valid_i is high.
    ready_o = bcast ? (&free) : tgt_free;
    accept  = valid_i && ready_o;
    if (accept) begin
      for (int k = 0; k < NUM_CH; k++) begin
        load[k] = bcast || (tgt == SEL_WIDTH'(k));
      end
    end
    drop_d = accept && !bcast && !tgt_ok;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      valid_o <= '0;
      data_o  <= '0;
      drop_o  <= 1'b0;
    end else begin
      drop_o <= drop_d;
      for (int k = 0; k < NUM_CH; k++) begin
        if (load[k]) begin
          // Load wins over a simultaneous drain: full rate with no bubble.
          valid_o[k]                           <= 1'b1;
          data_o[k*DATA_WIDTH +: DATA_WIDTH]   <= data_i;
        end else if (valid_o[k] && ready_i[k]) begin
          valid_o[k]                           <= 1'b0;
          data_o[k*DATA_WIDTH +: DATA_WIDTH]   <= '0;
        end
      end
    end
  end

  generate
    if (SEL_MODE != 0) begin : g_rr
      always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
          ptr_q <= '0;
        end else if (accept && !bcast) begin
          ptr_q <= (ptr_q == SEL_WIDTH'(NUM_CH - 1)) ? '0 : ptr_q + SEL_WIDTH'(1);
        end
      end
    end else begin : g_explicit
      assign ptr_q = '0;
    end
  endgenerate

  assign ptr_o = ptr_q;

endmodule

// File: tb/tb_demux_n_stream.sv
// tb/tb_demux_n_stream.sv - randomized self-checking bench for demux_n_stream
//
// Three instances share clock and reset: u0 (NUM_CH=4, explicit select),
// u1 (NUM_CH=4, round-robin), u2 (NUM_CH=3, explicit select with invalid code 3).
module tb_demux_n_stream;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [7:0] din  [3];
  logic       vin  [3];
  logic [1:0] sel  [3];
  logic [3:0] rin  [3];
  logic       bc   [3];

  logic        rdy0, rdy1, rdy2;
  logic [31:0] dout0, dout1;
  logic [23:0] dout2;
  logic [3:0]  vout0, vout1;
  logic [2:0]  vout2;
  logic [1:0]  ptr0, ptr1, ptr2;
  logic        drop0, drop1, drop2;

  demux_n_stream #(.DATA_WIDTH(8), .NUM_CH(4), .SEL_MODE(0)) u0 (
    .clk_i(clk), .rst_i(rst), .data_i(din[0]), .valid_i(vin[0]), .ready_o(rdy0),
    .sel_i(sel[0]), .data_o(dout0), .valid_o(vout0), .ready_i(rin[0]),
`ifdef DEMUX_BROADCAST_EN
    .bcast_i(bc[0]),
`endif
    .ptr_o(ptr0), .drop_o(drop0));

  demux_n_stream #(.DATA_WIDTH(8), .NUM_CH(4), .SEL_MODE(1)) u1 (
    .clk_i(clk), .rst_i(rst), .data_i(din[1]), .valid_i(vin[1]), .ready_o(rdy1),
    .sel_i(sel[1]), .data_o(dout1), .valid_o(vout1), .ready_i(rin[1]),
`ifdef DEMUX_BROADCAST_EN
    .bcast_i(bc[1]),
`endif
    .ptr_o(ptr1), .drop_o(drop1));

  demux_n_stream #(.DATA_WIDTH(8), .NUM_CH(3), .SEL_MODE(0)) u2 (
    .clk_i(clk), .rst_i(rst), .data_i(din[2]), .valid_i(vin[2]), .ready_o(rdy2),
    .sel_i(sel[2]), .data_o(dout2), .valid_o(vout2), .ready_i(rin[2][2:0]),
`ifdef DEMUX_BROADCAST_EN
    .bcast_i(bc[2]),
`endif
    .ptr_o(ptr2), .drop_o(drop2));

  // Reference model: slot contents per instance, pointer, drop pulse.
  int         nch  [3] = '{4, 4, 3};
  int         mode [3] = '{0, 1, 0};
  bit         mv   [3][4];
  logic [7:0] md   [3][4];
  int         mp   [3];
  bit         mdrop[3];

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic get_out(input int i, output logic [31:0] d, output logic [3:0] v,
                         output logic [1:0] p, output logic dr, output logic r);
    case (i)
      0:       begin d = dout0;          v = vout0;         p = ptr0; dr = drop0; r = rdy0; end
      1:       begin d = dout1;          v = vout1;         p = ptr1; dr = drop1; r = rdy1; end
      default: begin d = {8'h00, dout2}; v = {1'b0, vout2}; p = ptr2; dr = drop2; r = rdy2; end
    endcase
  endtask

  task automatic reset_model();
    for (int i = 0; i < 3; i++) begin
      mp[i] = 0;
      mdrop[i] = 1'b0;
      for (int k = 0; k < 4; k++) begin
        mv[i][k] = 1'b0;
        md[i][k] = 8'h00;
      end
    end
  endtask

  task automatic set_idle();
    for (int i = 0; i < 3; i++) begin
      din[i] = 8'h00; vin[i] = 1'b0; sel[i] = 2'd0; rin[i] = 4'hF; bc[i] = 1'b0;
    end
  endtask

  task automatic check_outputs();
    logic [31:0] d, ed;
    logic [3:0]  v, ev;
    logic [1:0]  p;
    logic        dr, r;
    for (int i = 0; i < 3; i++) begin
      get_out(i, d, v, p, dr, r);
      ev = '0;
      ed = '0;
      for (int k = 0; k < nch[i]; k++) begin
        ev[k] = mv[i][k];
        ed[k*8 +: 8] = md[i][k];
      end
      check($sformatf("valid u%0d cyc%0d", i, cyc), {28'b0, v}, {28'b0, ev});
      check($sformatf("data u%0d cyc%0d", i, cyc), d, ed);
      check($sformatf("ptr u%0d cyc%0d", i, cyc), {30'b0, p}, (mode[i] != 0) ? mp[i] : 0);
      check($sformatf("drop u%0d cyc%0d", i, cyc), {31'b0, dr}, {31'b0, mdrop[i]});
    end
  endtask

  // Called at a falling edge with inputs already set; checks ready, clocks once,
  // advances the model, then checks registered outputs at the next falling edge.
  task automatic cycle();
    bit          rd[3];
    int          tg[3];
    bit          fire;
    logic [31:0] d;
    logic [3:0]  v;
    logic [1:0]  p;
    logic        dr, r;
    #1;
    for (int i = 0; i < 3; i++) begin
      tg[i] = (mode[i] != 0) ? mp[i] : int'(sel[i]);
      if (bc[i]) begin
        rd[i] = 1'b1;
        for (int k = 0; k < nch[i]; k++) if (mv[i][k] && !rin[i][k]) rd[i] = 1'b0;
      end else if (tg[i] < nch[i]) begin
        rd[i] = !mv[i][tg[i]] || rin[i][tg[i]];
      end else begin
        rd[i] = 1'b1;
      end
      get_out(i, d, v, p, dr, r);
      check($sformatf("ready u%0d cyc%0d", i, cyc), {31'b0, r}, {31'b0, rd[i]});
    end
    @(posedge clk);
    for (int i = 0; i < 3; i++) begin
      fire = vin[i] && rd[i];
      mdrop[i] = fire && !bc[i] && (tg[i] >= nch[i]);
      for (int k = 0; k < nch[i]; k++) begin
        if (mv[i][k] && rin[i][k]) begin
          mv[i][k] = 1'b0;
          md[i][k] = 8'h00;
        end
      end
      if (fire) begin
        for (int k = 0; k < nch[i]; k++) begin
          if (bc[i] || tg[i] == k) begin
            mv[i][k] = 1'b1;
            md[i][k] = din[i];
          end
        end
        if (mode[i] != 0 && !bc[i]) mp[i] = (mp[i] + 1) % nch[i];
      end
    end
    cyc++;
    @(negedge clk);
    check_outputs();
  endtask

  initial begin
    set_idle();
    reset_model();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    check_outputs();
    rst = 1'b0;

    // Explicit routing into a blocked slot
    rin[0] = 4'h0; sel[0] = 2'd2; din[0] = 8'h11; vin[0] = 1'b1;
    cycle();
    check("t2 valid", {28'b0, vout0}, 32'h4);
    check("t2 slice2", {24'b0, dout0[23:16]}, 32'h11);
    din[0] = 8'h22;
    cycle();
    check("t2 hold", {24'b0, dout0[23:16]}, 32'h11);
    set_idle();
    cycle();

    // Full-rate routing with simultaneous drain and load
    for (int j = 0; j < 5; j++) begin
      sel[0] = 2'(j % 4); din[0] = 8'(j + 1); vin[0] = 1'b1;
      cycle();
    end
    set_idle();
    cycle();

    // Invalid target on the 3-channel instance
    sel[2] = 2'd3; din[2] = 8'h5A; vin[2] = 1'b1; rin[2] = 4'h0;
    cycle();
    check("t5 drop", {31'b0, drop2}, 32'h1);
    set_idle();
    cycle();

    // Round-robin fill until stall, then release
    for (int j = 0; j < 6; j++) begin
      vin[1] = 1'b1; din[1] = 8'(8'h30 + j); rin[1] = 4'h0;
      cycle();
    end
    set_idle();
    for (int j = 0; j < 3; j++) begin
      vin[1] = 1'b1; din[1] = 8'(8'h40 + j);
      cycle();
    end
    set_idle();
    cycle();

    // Randomized traffic
    for (int n = 0; n < 400; n++) begin
      for (int i = 0; i < 3; i++) begin
        vin[i] = ($urandom_range(0, 3) != 0);
        din[i] = 8'($urandom);
        sel[i] = 2'($urandom);
        rin[i] = 4'($urandom);
        bc[i]  = 1'b0;
      end
      cycle();
    end
    set_idle();
    cycle();

    // Asynchronous reset mid-stream with slots 0, 1, 3 occupied
    rin[0] = 4'h0;
    for (int j = 0; j < 3; j++) begin
      vin[0] = 1'b1; sel[0] = (j == 2) ? 2'd3 : 2'(j); din[0] = 8'(8'hC0 + j);
      cycle();
    end
    check("t1 pre-reset valid", {28'b0, vout0}, 32'hB);
    rst = 1'b1;
    #1;
    reset_model();
    check_outputs();
    set_idle();
    @(negedge clk);
    rst = 1'b0;
    cycle();

`ifdef DEMUX_BROADCAST_EN
    // Broadcast blocked by a full slot, then released
    rin[0] = 4'h0; vin[0] = 1'b1; sel[0] = 2'd1; din[0] = 8'h77;
    cycle();
    sel[0] = 2'd0; din[0] = 8'hA5; bc[0] = 1'b1;
    cycle();
    rin[0] = 4'b0010;
    cycle();
    check("t6 valid", {28'b0, vout0}, 32'hF);
    check("t6 data", dout0, 32'hA5A5A5A5);
    set_idle();
    cycle();
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
